// File: rtl/slowclock_pkg.sv
// Shared types and defaults for the slow-clock run/stop controller.
package slowclock_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam int CNT_W_DEF        = 13;
  localparam int DEFAULT_HALF_DEF = 2500;

endpackage

// File: rtl/slowclock_cnt.sv
// Half-period counter plus the slowclock toggle and tick flops.
// boundary flags the edge on which the current half-period ends.
module slowclock_cnt #(
  parameter int CNT_W = 13
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] half_act,
  output logic             boundary,
  output logic             slowclock,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count;

  assign boundary = en && !clr && (count == half_act - ONE);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      count     <= '0;
      slowclock <= 1'b0;
      tick      <= 1'b0;
    end else if (clr) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (en) begin
      if (boundary) begin
        count     <= '0;
        slowclock <= ~slowclock;
        tick      <= 1'b1;
      end else begin
        count <= count + ONE;
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/slowclock_ctrl.sv
// Slow-clock run/stop FSM with a shadowed half-period register that is
// applied only in IDLE or at half-period boundaries, so slowclock never glitches.
module slowclock_ctrl
  import slowclock_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             pending,
  output logic             slowclock,
  output logic             tick
);

  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] half_act;
  logic [CNT_W-1:0] shadow;
  logic             boundary;
  logic             stop_low;
  logic             clr;
  logic             en;
  logic             cfg_xfer;
  logic             apply;

  // Stopping while low ends the run immediately, so the counter must not toggle.
  assign stop_low  = (state == RUN) && stop && !slowclock;
  assign clr       = (state == IDLE) || stop_low;
  assign en        = !clr;

  assign busy      = (state != IDLE);
  assign cfg_ready = !pending;
  assign cfg_xfer  = cfg_valid && !pending;
  // pending is only set after an acceptance edge, so a same-edge transfer waits.
  assign apply     = pending && ((state == IDLE) || boundary);

  slowclock_cnt #(.CNT_W(CNT_W)) u_cnt (
    .CLOCK     (CLOCK),
    .RESET_N   (RESET_N),
    .en        (en),
    .clr       (clr),
    .half_act  (half_act),
    .boundary  (boundary),
    .slowclock (slowclock),
    .tick      (tick)
  );

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:     if (start && !stop) state <= RUN;
        RUN:      if (stop) state <= slowclock ? STOPPING : IDLE;
        STOPPING: begin
          if (boundary)   state <= IDLE;
          else if (start) state <= RUN;
        end
        default:  state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      half_act <= HALF_RST;
      shadow   <= '0;
      pending  <= 1'b0;
    end else if (apply) begin
      half_act <= shadow;
      pending  <= 1'b0;
    end else if (cfg_xfer) begin
      shadow  <= (cfg_half == '0) ? ONE : cfg_half;
      pending <= 1'b1;
    end
  end

endmodule
